fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I pipeline.
// Holds the fetch FSM encoding and the IF/ID bubble value.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the PC and keeps one imem request in flight.
// Presents instrF/PCF/PCPlus4F with a valid flag to IF/ID.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC =
    DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  instr_validF
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ibuf_q, ibuf_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] target;

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);
  assign target   = PCTargetE & ~DATA_WIDTH'(3);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ibuf_d  = ibuf_q;
    kill_d  = kill_q;
    if (PCSrcE) begin
      pc_d = target;
      unique case (state_q)
        WAIT: begin
          // A response already in flight must not reach IF/ID
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = FETCH;
            end else begin
              ibuf_d  = imem_rdata;
              state_d = VALID;
            end
          end
        end
        VALID: begin
          if (!stallF) begin
            pc_d    = pc_plus4;
            state_d = WAIT;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ibuf_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
      kill_q  <= kill_d;
    end
  end

  assign imem_req = rst_n && !PCSrcE &&
    ((state_q == FETCH) ||
     (state_q == VALID && !stallF));

  assign imem_addr =
    (state_q == VALID && imem_req) ? pc_plus4 : pc_q;

  assign instr_validF = (state_q == VALID) && !PCSrcE;
  assign instrF = instr_validF ? ibuf_q
                               : DATA_WIDTH'(BUBBLE_INSTR);
  assign PCF      = pc_q;
  assign PCPlus4F = pc_plus4;

  a_rvalid_in_wait : assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> state_q == WAIT
  ) else $error("imem_rvalid outside WAIT");

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-configurable imem.
// A second instance starts at 0xFFFF_FFFC to exercise PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrF, PCF, PCPlus4F;
  logic        instr_validF;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .instr_validF(instr_validF)
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stallF(stallF),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrF(w_instr), .PCF(w_pc), .PCPlus4F(w_pc4),
    .instr_validF(w_valid)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], 16'h0013};
  endfunction

  // imem model: rvalid exactly lat cycles after the request cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= 1'b0;
      cnt         <= 0;
      paddr       <= '0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (pend) begin
        if (cnt == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem(paddr);
          pend        <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req) begin
        if (lat == 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem(imem_addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= lat - 1;
          paddr <= imem_addr;
        end
      end
    end
  end

  task automatic do_reset(input int l);
    @(negedge clk);
    rst_n = 1'b0;
    stallF = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    lat = l;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got %h exp 0", imem_req); end
    checks++; if (instr_validF !== 1'b0) begin failures++; $display("FAIL rst_valid got %h exp 0", instr_validF); end
    checks++; if (instrF !== 32'h0) begin failures++; $display("FAIL rst_instr got %h exp 0", instrF); end
    checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL rst_pcf got %h exp 0", PCF); end
    checks++; if (PCPlus4F !== 32'h4) begin failures++; $display("FAIL rst_pc4 got %h exp 4", PCPlus4F); end
    checks++; if (w_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_wpc got %h exp fffffffc", w_pc); end
  endtask

  task automatic test_first_fetch;
    lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL ff_c0_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL ff_c0_addr got %h exp 0", imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ff_c1_req got %h exp 0", imem_req); end
    checks++; if (instr_validF !== 1'b0) begin failures++; $display("FAIL ff_c1_valid got %h exp 0", instr_validF); end
    @(negedge clk);
    checks++; if (instr_validF !== 1'b1) begin failures++; $display("FAIL ff_c2_valid got %h exp 1", instr_validF); end
    checks++; if (instrF !== 32'h0050_0093) begin failures++; $display("FAIL ff_c2_instr got %h exp 00500093", instrF); end
    checks++; if (PCF !== 32'h0) begin failures++; $display("FAIL ff_c2_pcf got %h exp 0", PCF); end
    checks++; if (PCPlus4F !== 32'h4) begin failures++; $display("FAIL ff_c2_pc4 got %h exp 4", PCPlus4F); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL ff_c2_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL ff_c2_addr got %h exp 4", imem_addr); end
  endtask

  task automatic test_sequential;
    logic [31:0] exp_i [4] = '{32'h0050_0093, 32'h0004_0013,
                               32'h0008_0013, 32'h000C_0013};
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] exp_a [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    do_reset(1);
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL seq_addr0 got %h exp 0", imem_addr); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (instr_validF !== 1'b0) begin failures++; $display("FAIL seq_wait%0d got %h exp 0", k, instr_validF); end
      @(negedge clk);
      checks++; if (instr_validF !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got %h exp 1", k, instr_validF); end
      checks++; if (PCF !== exp_pc[k]) begin failures++; $display("FAIL seq_pcf%0d got %h exp %h", k, PCF, exp_pc[k]); end
      checks++; if (instrF !== exp_i[k]) begin failures++; $display("FAIL seq_instr%0d got %h exp %h", k, instrF, exp_i[k]); end
      checks++; if (imem_addr !== exp_a[k]) begin failures++; $display("FAIL seq_addr%0d got %h exp %h", k, imem_addr, exp_a[k]); end
    end
  endtask

  task automatic test_stall;
    do_reset(1);
    repeat (6) @(negedge clk);
    checks++; if (PCF !== 32'h8 || instr_validF !== 1'b1) begin failures++; $display("FAIL st_pre got pc=%h v=%h exp pc=8 v=1", PCF, instr_validF); end
    stallF = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL st_req0 got %h exp 0", imem_req); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (instr_validF !== 1'b1) begin failures++; $display("FAIL st_valid%0d got %h exp 1", k, instr_validF); end
      checks++; if (PCF !== 32'h8) begin failures++; $display("FAIL st_pcf%0d got %h exp 8", k, PCF); end
      checks++; if (PCPlus4F !== 32'hC) begin failures++; $display("FAIL st_pc4%0d got %h exp c", k, PCPlus4F); end
      checks++; if (instrF !== 32'h0008_0013) begin failures++; $display("FAIL st_instr%0d got %h exp 00080013", k, instrF); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL st_req%0d got %h exp 0", k, imem_req); end
    end
    @(negedge clk);
    stallF = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL st_rel_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL st_rel_addr got %h exp c", imem_addr); end
    checks++; if (PCF !== 32'h8) begin failures++; $display("FAIL st_rel_pcf got %h exp 8", PCF); end
    @(negedge clk);
    checks++; if (PCF !== 32'hC || instr_validF !== 1'b0) begin failures++; $display("FAIL st_wait got pc=%h v=%h exp pc=c v=0", PCF, instr_validF); end
    @(negedge clk);
    checks++; if (instrF !== 32'h000C_0013) begin failures++; $display("FAIL st_next got %h exp 000c0013", instrF); end
  endtask

  task automatic test_redirect_wait;
    bit found;
    do_reset(3);
    repeat (5) @(negedge clk);
    checks++; if (PCF !== 32'h4 || imem_req !== 1'b0) begin failures++; $display("FAIL rw_pre got pc=%h r=%h exp pc=4 r=0", PCF, imem_req); end
    PCSrcE = 1'b1;
    PCTargetE = 32'h40;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_validF !== 1'b0) begin failures++; $display("FAIL rw_c5 got r=%h v=%h exp 0 0", imem_req, instr_validF); end
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    checks++; if (PCF !== 32'h40) begin failures++; $display("FAIL rw_pcf got %h exp 40", PCF); end
    @(negedge clk);
    checks++; if (instr_validF !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rw_drop got v=%h r=%h exp 0 0", instr_validF, imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL rw_req got r=%h a=%h exp 1 40", imem_req, imem_addr); end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (instr_validF === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rw_timeout got none exp valid"); end
    checks++; if (PCF !== 32'h40) begin failures++; $display("FAIL rw_vpc got %h exp 40", PCF); end
    checks++; if (instrF !== 32'h0040_0013) begin failures++; $display("FAIL rw_instr got %h exp 00400013", instrF); end
  endtask

  task automatic test_redirect_rvalid;
    do_reset(1);
    @(negedge clk);
    PCSrcE = 1'b1;
    PCTargetE = 32'h102;
    #1;
    checks++; if (instr_validF !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rr_c1 got v=%h r=%h exp 0 0", instr_validF, imem_req); end
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    checks++; if (PCF !== 32'h100) begin failures++; $display("FAIL rr_pcf got %h exp 100", PCF); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rr_req got r=%h a=%h exp 1 100", imem_req, imem_addr); end
    checks++; if (instr_validF !== 1'b0) begin failures++; $display("FAIL rr_valid got %h exp 0", instr_validF); end
    @(negedge clk);
    checks++; if (instr_validF !== 1'b0) begin failures++; $display("FAIL rr_c3 got %h exp 0", instr_validF); end
    @(negedge clk);
    checks++; if (instr_validF !== 1'b1 || instrF !== 32'h0100_0013) begin failures++; $display("FAIL rr_c4 got v=%h i=%h exp 1 01000013", instr_validF, instrF); end
  endtask

  task automatic test_back_to_back;
    do_reset(3);
    @(negedge clk);
    PCSrcE = 1'b1;
    PCTargetE = 32'h200;
    @(negedge clk);
    PCTargetE = 32'h300;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bb_req got %h exp 0", imem_req); end
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    checks++; if (PCF !== 32'h300) begin failures++; $display("FAIL bb_pcf got %h exp 300", PCF); end
    checks++; if (instr_validF !== 1'b0) begin failures++; $display("FAIL bb_drop got %h exp 0", instr_validF); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL bb_req2 got r=%h a=%h exp 1 300", imem_req, imem_addr); end
    repeat (4) @(negedge clk);
    checks++; if (instr_validF !== 1'b1 || instrF !== 32'h0300_0013) begin failures++; $display("FAIL bb_valid got v=%h i=%h exp 1 03000013", instr_validF, instrF); end
  endtask

  task automatic test_pc_wrap;
    do_reset(1);
    checks++; if (w_pc4 !== 32'h0) begin failures++; $display("FAIL wr_pc4 got %h exp 0", w_pc4); end
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_req0 got r=%h a=%h exp 1 fffffffc", w_req, w_addr); end
    repeat (2) @(negedge clk);
    checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_valid got v=%h pc=%h exp 1 fffffffc", w_valid, w_pc); end
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin failures++; $display("FAIL wr_req1 got r=%h a=%h exp 1 0", w_req, w_addr); end
    repeat (2) @(negedge clk);
    checks++; if (w_pc !== 32'h0 || w_pc4 !== 32'h4) begin failures++; $display("FAIL wr_adv got pc=%h pc4=%h exp 0 4", w_pc, w_pc4); end
  endtask

  task automatic test_reset_mid_wait;
    do_reset(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_validF !== 1'b0) begin failures++; $display("FAIL rm_rst got r=%h v=%h exp 0 0", imem_req, instr_validF); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rm_req got r=%h a=%h exp 1 0", imem_req, imem_addr); end
    repeat (3) @(negedge clk);
    checks++; if (instr_validF !== 1'b0) begin failures++; $display("FAIL rm_stale got %h exp 0", instr_validF); end
    @(negedge clk);
    checks++; if (instr_validF !== 1'b1 || instrF !== 32'h0050_0093) begin failures++; $display("FAIL rm_valid got v=%h i=%h exp 1 00500093", instr_validF, instrF); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
